// File: rtl/sequenciador_soma_pkg.sv
`default_nettype none
// +---------------------------------------------------------------------+
// | sequenciador_soma_pkg                                               |
// | Shared types and constants for the multi-nibble addition sequencer. |
// | Revision: 1.0                                                       |
// +---------------------------------------------------------------------+
package sequenciador_soma_pkg;

  localparam int c_nib_w       = 4;
  localparam int c_max_nib_min = 1;
  localparam int c_max_nib_max = 15;

  typedef enum logic [0:0] {
    OCIOSO = 1'b0,
    MEIO   = 1'b1
  } seq_state_t;

  function automatic int clamp_max_nib(input int max_nib);
    if (max_nib < c_max_nib_min) return c_max_nib_min;
    if (max_nib > c_max_nib_max) return c_max_nib_max;
    return max_nib;
  endfunction

  // Counter only needs to reach max_nib-1; keep at least one bit.
  function automatic int cnt_width(input int max_nib);
    return (max_nib > 1) ? $clog2(max_nib) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sequenciador_soma_if.sv
`default_nettype none
// +---------------------------------------------------------------------+
// | sequenciador_soma_if                                                |
// | Operand stream, adder hookup and result stream of the sequencer.    |
// | in_sub exists only when SEQ_SUB_EN is defined.                      |
// | Revision: 1.0                                                       |
// +---------------------------------------------------------------------+
interface sequenciador_soma_if;
  import sequenciador_soma_pkg::*;

  logic               in_valid;
  logic               in_ready;
  logic [c_nib_w-1:0] in_a;
  logic [c_nib_w-1:0] in_b;
  logic               in_last;
`ifdef SEQ_SUB_EN
  logic               in_sub;
`endif
  logic [c_nib_w-1:0] add_a;
  logic [c_nib_w-1:0] add_b;
  logic               add_cin;
  logic [c_nib_w-1:0] add_s;
  logic               add_cout;
  logic               out_valid;
  logic               out_ready;
  logic [c_nib_w-1:0] out_s;
  logic               out_last;
  logic               out_cout;
  logic               out_zero;
  logic               out_ovf;
  logic               out_trunc;

  modport slave (
`ifdef SEQ_SUB_EN
    input  in_sub,
`endif
    input  in_valid, in_a, in_b, in_last, add_s, add_cout, out_ready,
    output in_ready, add_a, add_b, add_cin,
    output out_valid, out_s, out_last, out_cout, out_zero, out_ovf, out_trunc
  );

  modport master (
`ifdef SEQ_SUB_EN
    output in_sub,
`endif
    output in_valid, in_a, in_b, in_last, add_s, add_cout, out_ready,
    input  in_ready, add_a, add_b, add_cin,
    input  out_valid, out_s, out_last, out_cout, out_zero, out_ovf, out_trunc
  );

endinterface
`default_nettype wire

// File: rtl/sequenciador_soma.sv
`default_nettype none
// +---------------------------------------------------------------------+
// | sequenciador_soma                                                   |
// | Chains an external 4-bit adder over LSB-first nibbles and emits     |
// | registered result nibbles with word flags. SEQ_SUB_EN adds in_sub.  |
// | Revision: 1.0                                                       |
// +---------------------------------------------------------------------+
module sequenciador_soma
  import sequenciador_soma_pkg::*;
#(
  parameter int MAX_NIB = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  sequenciador_soma_if.slave  bus
);

  localparam int                 c_max_nib  = clamp_max_nib(MAX_NIB);
  localparam int                 c_cnt_w    = cnt_width(c_max_nib);
  localparam logic [c_cnt_w-1:0] c_last_cnt = c_cnt_w'(c_max_nib - 1);

  seq_state_t         r_state;
  seq_state_t         w_next_state;
  logic               r_carry;
  logic [c_cnt_w-1:0] r_cnt;
  logic               r_zero;
  logic               r_out_valid;
  logic [c_nib_w-1:0] r_out_s;
  logic               r_out_last;
  logic               r_out_cout;
  logic               r_out_zero;
  logic               r_out_ovf;
  logic               r_out_trunc;
  logic               w_accept;
  logic               w_end;
  logic               w_sub;
  logic               w_zero_acc;
  logic               w_ovf;

`ifdef SEQ_SUB_EN
  logic r_sub;
  // Mode is taken from the first nibble and held for the rest of the word.
  assign w_sub = (r_state == OCIOSO) ? bus.in_sub : r_sub;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_sub <= 1'b0;
    else if (w_accept) r_sub <= w_sub;
  end
`else
  assign w_sub = 1'b0;
`endif

  assign bus.in_ready = !r_out_valid || bus.out_ready;
  assign w_accept     = bus.in_valid && bus.in_ready;
  assign bus.add_a    = bus.in_a;
  assign bus.add_b    = w_sub ? ~bus.in_b : bus.in_b;
  assign bus.add_cin  = (r_state == OCIOSO) ? w_sub : r_carry;
  assign w_end        = bus.in_last || (r_cnt == c_last_cnt);
  assign w_zero_acc   = r_zero && (bus.add_s == '0);
  // Carry out of the MSB xor carry into the MSB.
  assign w_ovf        = bus.add_cout ^ (bus.add_s[c_nib_w-1] ^ bus.add_a[c_nib_w-1]
                                        ^ bus.add_b[c_nib_w-1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= OCIOSO;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    if (w_accept) w_next_state = w_end ? OCIOSO : MEIO;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_carry     <= 1'b0;
      r_cnt       <= '0;
      r_zero      <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_s     <= '0;
      r_out_last  <= 1'b0;
      r_out_cout  <= 1'b0;
      r_out_zero  <= 1'b0;
      r_out_ovf   <= 1'b0;
      r_out_trunc <= 1'b0;
    end else begin
      if (w_accept) begin
        r_out_valid <= 1'b1;
        r_out_s     <= bus.add_s;
        r_out_last  <= w_end;
        r_out_cout  <= w_end && bus.add_cout;
        r_out_zero  <= w_end && w_zero_acc;
        r_out_ovf   <= w_end && w_ovf;
        r_out_trunc <= w_end && !bus.in_last;
        r_carry     <= bus.add_cout;
        r_cnt       <= w_end ? '0 : r_cnt + 1'b1;
        r_zero      <= w_end ? 1'b1 : w_zero_acc;
      end else if (bus.out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.out_s     = r_out_s;
  assign bus.out_last  = r_out_last;
  assign bus.out_cout  = r_out_cout;
  assign bus.out_zero  = r_out_zero;
  assign bus.out_ovf   = r_out_ovf;
  assign bus.out_trunc = r_out_trunc;

endmodule
`default_nettype wire

// File: doc/sequenciador_soma.md
# sequenciador_soma

Multi-nibble addition sequencer wrapped around the 4-bit ripple-carry adder stage of the ULA. It accepts operand nibbles LSB-first on a valid/ready stream and drives the adder's A, B and carry-in. It captures the adder's sum and carry-out each cycle and chains the carry into the next nibble, so words wider than 4 bits can be added. It emits registered result nibbles with word-level carry, zero and signed-overflow flags to the downstream stage.

## Interface
- MAX_NIB, 4: maximum nibbles per word (range 1–15); a word is force-terminated at this count.
- clk  input  1  rising-edge clock, single domain.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand nibble pair present.
- in_ready  output  1  sequencer accepts a nibble this cycle.
- in_a  input  4  operand A nibble.
- in_b  input  4  operand B nibble.
- in_last  input  1  this nibble is the MSB nibble of the word.
- add_a  output  4  to adder A; combinationally equals in_a.
- add_b  output  4  to adder B; in_b, or ~in_b when subtracting.
- add_cin  output  1  to adder carry-in; chained carry register, or word-start carry.
- add_s  input  4  adder sum.
- add_cout  input  1  adder carry-out.
- out_valid  output  1  result nibble valid.
- out_ready  input  1  downstream accepts.
- out_s  output  4  result nibble.
- out_last  output  1  final nibble of word.
- out_cout  output  1  word carry-out; valid with out_last.
- out_zero  output  1  all nibbles of the word are zero; valid with out_last.
- out_ovf  output  1  signed overflow of the word; valid with out_last.
- out_trunc  output  1  word ended by MAX_NIB rather than in_last.

## Operation
- States: OCIOSO (word boundary) and MEIO (mid-word).
- Word-start carry cin0: 0 for add, 1 for subtract.
- add_cin = cin0 in OCIOSO; carry register in MEIO.
- Accept: in_valid && in_ready. On accept, load the output register with add_s. Update the carry register with add_cout. Increment the nibble counter. AND the zero accumulator with (add_s == 0).
- End of word: in_last, or the counter reaching MAX_NIB−1 on this nibble. Then:
  - out_last = 1; out_cout = add_cout; out_zero = accumulated zero.
  - out_ovf = add_cout ^ (add_s[3]^add_a[3]^add_b[3]).
  - out_trunc = !in_last.
  - Next state OCIOSO; counter = 0; zero accumulator = 1.
- Otherwise, next state MEIO. out_last, out_cout, out_zero, out_ovf and out_trunc are 0 on non-final nibbles.
- in_ready = !out_valid || out_ready. This gives full throughput and single-entry buffering; there is no skid buffer.
- out_valid is set on accept and cleared when out_ready && !accept. Output fields are held stable while out_valid && !out_ready.
- Simultaneous output drain and new accept in the same cycle: the register is reloaded and out_valid stays 1.
- After a forced termination, the next accepted nibble starts a new word with cin0.

## Timing
- Adder path is combinational within one cycle: in_* to add_* to add_s/add_cout to the capture flops.
- Latency: 1 cycle from accept to out_valid.
- Throughput: 1 nibble/cycle when out_ready is held at 1.
- Reset values (asynchronous, while rst_n = 0):
  - state OCIOSO, carry register 0, counter 0, zero accumulator 1.
  - out_valid 0, out_s 0, and all out flags 0.
  - in_ready 1.
- Reset mid-word discards the partial word. No flush nibble is emitted.

## Configuration
- SEQ_SUB_EN defined:
  - Adds input port in_sub (1 bit), sampled on the first nibble of each word and latched for the whole word.
  - When set: add_b = ~in_b and cin0 = 1.
  - out_cout = 1 means no borrow.
- SEQ_SUB_EN undefined: no in_sub port; add only; cin0 = 0.

## Structure
- Shared package: state encoding (OCIOSO, MEIO), nibble width constant 4, and the MAX_NIB range limits.
- The nibble counter width is derived from MAX_NIB.
- No sub-module inside. The adder stays external and is connected by the parent, so the sequencer can be verified against a behavioural adder model.

## Test plan
- Single nibble 7+1, in_last = 1 -> out_s = 8, out_cout = 0, out_ovf = 1, out_zero = 0.
- 0x0F + 0x01 over two nibbles -> out_s 0x0 then 0x1; out_last on the second; out_cout = 0; out_zero = 0.
- 0xFFFF + 0x0001 over four nibbles -> four nibbles of 0x0; out_cout = 1; out_zero = 1; out_ovf = 0.
- Five nibbles with no in_last, MAX_NIB = 4 -> 4th nibble has out_last = 1 and out_trunc = 1; the 5th nibble uses add_cin = 0.
- out_ready held low for 3 cycles mid-word -> in_ready = 0, out_s stable, carry preserved; result matches the unstalled run.
- rst_n pulsed after 2 of 4 nibbles -> outputs at reset values. Next word 0x3+0x4 gives out_s = 7. With SEQ_SUB_EN, 3−5 gives out_s = 0xE and out_cout = 0.
